// File: rtl/datastream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datastream_pkg : shared types and constants for the datastream sender |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package datastream_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int SENT_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sender_state_t;

endpackage
`default_nettype wire

// File: rtl/datastream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datastream_fifo : power-of-two FIFO with registered level/full        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module datastream_fifo
  import datastream_pkg::*;
#(
  parameter int DATASIZE   = DATASIZE_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [DATASIZE-1:0]           data_i,
  input  logic                          pop_i,
  output logic [DATASIZE-1:0]           head_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          full_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("datastream_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DATASIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q,  level_d;
  logic                w_push, w_pop;

  assign full_o  = (level_q == LW'(FIFO_DEPTH));
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/datastream_sender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datastream_sender : FIFO-buffered valid/ready streamer with bursts    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module datastream_sender
  import datastream_pkg::*;
#(
  parameter int DATASIZE   = DATASIZE_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATASIZE-1:0]           wr_data_i,
  input  logic                          wr_en_i,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [DATASIZE-1:0]           data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [SENT_CNT_W-1:0]         sent_count_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam bit            GAP_EN     = (GAP_CYCLES > 0);

  sender_state_t           state_q, state_d;
  logic [BW-1:0]           burst_q, burst_d;
  logic [GW-1:0]           gap_q,   gap_d;
  logic [SENT_CNT_W-1:0]   sent_q,  sent_d;
  logic [DATASIZE-1:0]     w_head;
  logic                    w_xfer;
  logic                    w_push_ok;

  assign w_xfer       = (state_q == SEND) && ready_i;
  assign w_push_ok    = wr_en_i && !full_o;
  assign sent_count_o = sent_q;

  datastream_fifo #(
    .DATASIZE   (DATASIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_en_i),
    .data_i  (wr_data_i),
    .pop_i   (w_xfer),
    .head_o  (w_head),
    .level_o (level_o),
    .full_o  (full_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      burst_q <= '0;
      gap_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    sent_d  = w_xfer ? sent_q + SENT_CNT_W'(1) : sent_q;
    case (state_q)
      IDLE: begin
        if (level_o != '0) state_d = SEND;
      end
      SEND: begin
        if (w_xfer) begin
          if (GAP_EN && (burst_q == BURST_LAST)) begin
            state_d = GAP;
            burst_d = '0;
            gap_d   = '0;
          end else begin
            burst_d = burst_q + BW'(1);
            // Leaving the last word behind only if a push refills the FIFO.
            if ((level_o > LW'(1)) || w_push_ok) state_d = SEND;
            else                                 state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_o = (state_q == SEND);
    data_o  = valid_o ? w_head : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_datastream_sender.sv
`default_nettype none
// Directed bench: one sender with gaps disabled, one with BURST_LEN=4 / GAP_CYCLES=2.
module tb_datastream_sender;
  import datastream_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  n_wr_data, g_wr_data, n_data, g_data;
  logic        n_wr_en, g_wr_en, n_ready, g_ready;
  logic        n_full, g_full, n_valid, g_valid;
  logic [3:0]  n_level, g_level;
  logic [15:0] n_cnt, g_cnt;

  datastream_sender #(.DATASIZE(8), .FIFO_DEPTH(8), .BURST_LEN(4), .GAP_CYCLES(0)) dut_n (
    .clk_i(clk), .rst_i(rst), .wr_data_i(n_wr_data), .wr_en_i(n_wr_en),
    .full_o(n_full), .level_o(n_level), .data_o(n_data), .valid_o(n_valid),
    .ready_i(n_ready), .sent_count_o(n_cnt)
  );

  datastream_sender #(.DATASIZE(8), .FIFO_DEPTH(8), .BURST_LEN(4), .GAP_CYCLES(2)) dut_g (
    .clk_i(clk), .rst_i(rst), .wr_data_i(g_wr_data), .wr_en_i(g_wr_en),
    .full_o(g_full), .level_o(g_level), .data_o(g_data), .valid_o(g_valid),
    .ready_i(g_ready), .sent_count_o(g_cnt)
  );

  typedef struct {
    logic        we;
    logic [7:0]  wd;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic [3:0]  el;
    logic        ef;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic we, input logic [7:0] wd, input logic rdy,
                              input logic ev, input logic [7:0] ed, input logic [3:0] el,
                              input logic ef, input logic [15:0] ec);
    vec_t v;
    v.we = we; v.wd = wd; v.rdy = rdy; v.ev = ev; v.ed = ed; v.el = el; v.ef = ef; v.ec = ec;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    n_wr_en = 1'b0; n_wr_data = 8'h00; n_ready = 1'b0;
    g_wr_en = 1'b0; g_wr_data = 8'h00; g_ready = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int gpat [19] = '{0,1,1,1,1,0,0,0,1,1,1,1,0,0,0,1,1,0,0};
  int ppat [8]  = '{0,1,1,0,0,0,1,0};

  initial begin
    int k;
    int pushed, xfers, order_err;
    logic accepted, is_xfer;
    logic [7:0] pdata [3];

    // Vector table for the gap-free instance
    add(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0, 16'd0);
    add(1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 4'd2, 1'b0, 16'd0);
    add(1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 4'd2, 1'b0, 16'd1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 4'd1, 1'b0, 16'd2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 16'd3);
    add(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 16'd3);
    for (int i = 0; i < 5; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'd1, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 16'd4);
    add(1'b1, 8'h5C, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 16'd4);
    add(1'b0, 8'h00, 1'b0, 1'b1, 8'h5C, 4'd1, 1'b0, 16'd4);
    add(1'b1, 8'h6D, 1'b1, 1'b1, 8'h6D, 4'd1, 1'b0, 16'd5);
    add(1'b1, 8'h7E, 1'b1, 1'b1, 8'h7E, 4'd1, 1'b0, 16'd6);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 16'd7);
    add(1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 16'd7);
    for (int i = 1; i < 8; i++)
      add(1'b1, 8'(8'h80 + i), 1'b0, 1'b1, 8'h80, 4'(i + 1), (i == 7), 16'd7);
    add(1'b1, 8'h88, 1'b0, 1'b1, 8'h80, 4'd8, 1'b1, 16'd7);
    for (int j = 0; j < 8; j++)
      add(1'b0, 8'h00, 1'b1, (j < 7), (j < 7) ? 8'(8'h81 + j) : 8'h00, 4'(7 - j), 1'b0, 16'(8 + j));
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 16'd15);

    // Reset values asserted between clock edges
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    chk("rst_n_valid", n_valid, 0); chk("rst_n_data", n_data, 0);
    chk("rst_n_level", n_level, 0); chk("rst_n_full", n_full, 0);
    chk("rst_n_cnt", n_cnt, 0);     chk("rst_g_valid", g_valid, 0);
    chk("rst_g_level", g_level, 0); chk("rst_g_cnt", g_cnt, 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      n_wr_en = vecs[i].we; n_wr_data = vecs[i].wd; n_ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d.valid", i), n_valid, vecs[i].ev);
      chk($sformatf("vec%0d.data", i),  n_data,  vecs[i].ed);
      chk($sformatf("vec%0d.level", i), n_level, vecs[i].el);
      chk($sformatf("vec%0d.full", i),  n_full,  vecs[i].ef);
      chk($sformatf("vec%0d.count", i), n_cnt,   vecs[i].ec);
    end

    // Burst/gap pattern: 10 words, ready held high
    do_reset();
    k = 0;
    for (int e = 0; e < 19; e++) begin
      g_wr_en = (e < 10); g_wr_data = 8'(8'h30 + e); g_ready = 1'b1;
      tick();
      chk($sformatf("gap_e%0d.valid", e + 1), g_valid, gpat[e]);
      if (gpat[e] != 0) begin
        chk($sformatf("gap_e%0d.data", e + 1), g_data, 8'(8'h30 + k));
        k++;
      end else begin
        chk($sformatf("gap_e%0d.data", e + 1), g_data, 0);
      end
    end
    chk("gap_count", g_cnt, 10);
    chk("gap_level", g_level, 0);

    // Burst counter persists across IDLE; push accepted while in GAP
    pdata[0] = 8'hE0; pdata[1] = 8'hE1; pdata[2] = 8'hE2;
    k = 0;
    for (int e = 0; e < 8; e++) begin
      g_wr_en = (e == 0) || (e == 1) || (e == 4);
      g_wr_data = (e == 4) ? 8'hE2 : ((e == 1) ? 8'hE1 : 8'hE0);
      g_ready = 1'b1;
      tick();
      chk($sformatf("persist_e%0d.valid", e + 1), g_valid, ppat[e]);
      if (ppat[e] != 0) begin
        chk($sformatf("persist_e%0d.data", e + 1), g_data, pdata[k]);
        k++;
      end
      if (e == 4) chk("persist_push_in_gap.level", g_level, 1);
    end
    chk("persist_count", g_cnt, 13);
    idle_inputs();

    // Asynchronous reset mid-burst with 5 words buffered
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_wr_en = 1'b1; n_wr_data = 8'(8'hA0 + i); n_ready = 1'b0;
      tick();
    end
    n_wr_en = 1'b0; n_ready = 1'b1;
    tick();
    chk("midrst_pre.level", n_level, 4);
    chk("midrst_pre.count", n_cnt, 1);
    #3 rst = 1'b1;
    #1;
    chk("midrst.valid", n_valid, 0); chk("midrst.data", n_data, 0);
    chk("midrst.level", n_level, 0); chk("midrst.full", n_full, 0);
    chk("midrst.count", n_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    n_wr_en = 1'b1; n_wr_data = 8'h42; n_ready = 1'b0;
    tick();
    chk("post_rst_first_push.level", n_level, 1);
    chk("post_rst_first_push.valid", n_valid, 0);
    n_wr_en = 1'b0; n_ready = 1'b1;
    tick();
    chk("post_rst.valid", n_valid, 1);
    chk("post_rst.data", n_data, 8'h42);
    tick();
    chk("post_rst_drain.valid", n_valid, 0);
    chk("post_rst_drain.count", n_cnt, 1);

    // sent_count_o wrap after 65536 transfers
    do_reset();
    n_ready = 1'b1;
    pushed = 0; xfers = 0; order_err = 0;
    for (int cyc = 0; cyc < 70000 && xfers < 65536; cyc++) begin
      n_wr_en   = (pushed < 65536);
      n_wr_data = 8'(pushed);
      accepted  = n_wr_en && !n_full;
      is_xfer   = n_valid && n_ready;
      if (is_xfer && (n_data !== 8'(xfers))) order_err++;
      tick();
      if (accepted) pushed++;
      if (is_xfer) begin
        xfers++;
        if (xfers == 65535) chk("wrap_ffff.count", n_cnt, 16'hFFFF);
      end
    end
    n_wr_en = 1'b0;
    chk("wrap_budget.xfers", xfers, 65536);
    chk("wrap.count", n_cnt, 0);
    chk("wrap.order_errors", order_err, 0);
    tick();
    chk("wrap.level", n_level, 0);
    chk("wrap.valid", n_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datastream_sender.md
DATASTREAM_SENDER -- requirements
Module: datastream_sender

Interface
REQ-001 Parameter DATASIZE, default 8: width of every data word in bits.
REQ-002 Parameter FIFO_DEPTH, default 8: number of buffered words; SHALL be a power of 2, at least 2.
REQ-003 Parameter BURST_LEN, default 4: number of transfers sent before an inter-burst gap; at least 1.
REQ-004 Parameter GAP_CYCLES, default 2: number of idle cycles inserted after each burst; 0 disables gaps.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 wr_data_i  in  DATASIZE  word pushed into the internal FIFO.
REQ-008 wr_en_i  in  1  push request, qualified by !full_o.
REQ-009 full_o  out  1  FIFO holds FIFO_DEPTH words.
REQ-010 level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 data_o  out  DATASIZE  stream data towards the analyzer.
REQ-012 valid_o  out  1  data_o carries a word.
REQ-013 ready_i  in  1  analyzer accepts the word.
REQ-014 sent_count_o  out  16  number of completed transfers, modulo 2^16.

Function
REQ-015 A push SHALL occur on a clock edge when wr_en_i=1 and full_o=0. When full_o=1, wr_en_i SHALL be ignored with no state change.
REQ-016 A transfer SHALL occur on a clock edge when valid_o=1 and ready_i=1. A transfer pops the FIFO head.
REQ-017 full_o SHALL equal (level_o==FIFO_DEPTH). Both outputs SHALL be registered-state-derived, with no combinational path from wr_en_i.
REQ-018 Simultaneous push and pop SHALL leave level_o unchanged. FIFO order is strict first-in first-out. Pointers wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have exactly three states: IDLE, SEND, GAP. valid_o SHALL be 1 only in SEND.
REQ-020 IDLE: go to SEND on the next edge if level_o>0; otherwise stay in IDLE.
REQ-021 SEND: valid_o=1 and data_o=FIFO head. Without a transfer, the FSM stays in SEND and data_o is held stable.
REQ-022 SEND with a transfer, when the burst counter equals BURST_LEN-1 and GAP_CYCLES>0: go to GAP and clear the burst counter.
REQ-023 SEND with a transfer, otherwise: increment the burst counter. Stay in SEND if (level_o-1+push)>0, else go to IDLE.
REQ-024 GAP: stay for exactly GAP_CYCLES cycles with valid_o=0, then go to IDLE. The FIFO SHALL still accept pushes during GAP.
REQ-025 When GAP_CYCLES=0, the burst counter SHALL have no effect on the FSM.
REQ-026 The burst counter SHALL persist across IDLE. Only a gap or reset clears it.
REQ-027 Latency: a word pushed into an empty FIFO on edge N SHALL appear with valid_o=1 after edge N+1.
REQ-028 Throughput SHALL be one transfer per cycle while ready_i=1, the FIFO is non-empty, and no gap is active.
REQ-029 data_o SHALL be 0 whenever valid_o=0.
REQ-030 sent_count_o SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.

Reset
REQ-031 While rst_i=1, regardless of clk_i, the outputs SHALL be: state=IDLE, valid_o=0, data_o=0, full_o=0, level_o=0, sent_count_o=0.
REQ-032 Reset SHALL also clear the burst counter, gap counter and FIFO pointers.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered words. FIFO storage itself need not be reset.
REQ-034 The first push SHALL be accepted on the first rising edge after rst_i deasserts.

Structure
REQ-035 Package datastream_pkg SHALL hold the sender_state_t enum (IDLE, SEND, GAP), the default DATASIZE and the sent-counter width constant (16).
REQ-036 The FIFO SHALL be a separate sub-module, datastream_fifo (parameters DATASIZE and FIFO_DEPTH; push/pop/head/level/full ports).
REQ-037 The FSM, burst/gap counters and sent counter SHALL reside in datastream_sender.

Verification
REQ-038 Back-to-back: push 0x11,0x22,0x33 with ready_i=1 and GAP_CYCLES=0 -> valid_o high 3 consecutive cycles, data 0x11,0x22,0x33, sent_count_o=3, level_o=0, FSM returns to IDLE.
REQ-039 Backpressure: push 0xA5, hold ready_i=0 for 5 cycles -> valid_o=1 and data_o=0xA5 stable all 5 cycles; transfer on the first ready_i=1 edge.
REQ-040 Full: 9 pushes with ready_i=0 (DEPTH 8) -> full_o=1 and level_o=8; the 9th word is dropped; the popped sequence contains only the first 8 words.
REQ-041 Burst gap: BURST_LEN=4, GAP_CYCLES=2, 10 words, ready_i=1 -> pattern 4 valid, 2 idle, IDLE->SEND (1 idle), 4 valid, gap, 2 valid; all 10 words in order.
REQ-042 Simultaneous push/pop at level 1 in SEND -> level_o stays 1 and valid_o stays 1 without a bubble.
REQ-043 Async reset mid-burst with 5 words buffered -> valid_o, level_o and sent_count_o go to 0 immediately; FSM returns to IDLE; no stale word appears afterwards. Counter wrap: 65536 transfers -> sent_count_o=0.
